// File: rtl/joint_step_driver.sv
// rtl/joint_step_driver.sv - dual-joint STEP/DIR driver with pending target; define JOINT_LIMIT_EN to clamp targets
module joint_step_driver #(
   parameter int STEP_PERIOD = 1000,
   parameter int PULSE_WIDTH = 100,
   parameter int DIR_SETUP   = 50,
   parameter int TH_MIN      = -2048,
   parameter int TH_MAX      = 2047
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [12:0] th1,
   input  logic signed [12:0] th2,
   input  logic               dataReady,
   output logic               step1,
   output logic               step2,
   output logic               dir1,
   output logic               dir2,
   output logic signed [12:0] pos1,
   output logic signed [12:0] pos2,
   output logic               busy,
   output logic               moveDone
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int CW = $clog2(STEP_PERIOD + 1);
   localparam int SW = $clog2(DIR_SETUP + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_PERIOD - 1);
   localparam logic [CW-1:0] CNT_PW   = CW'(PULSE_WIDTH);
   localparam logic [SW-1:0] SU_LAST  = SW'(DIR_SETUP - 1);

`ifdef JOINT_LIMIT_EN
   function automatic logic signed [12:0] limit(input logic signed [12:0] th);
      if (int'(th) < TH_MIN)
         return 13'(TH_MIN);
      else if (int'(th) > TH_MAX)
         return 13'(TH_MAX);
      else
         return th;
   endfunction
`else
   function automatic logic signed [12:0] limit(input logic signed [12:0] th);
      return th;
   endfunction
   // Limits are meaningless without clamping; keep them referenced
   logic unused_limits;
   assign unused_limits = (TH_MIN > TH_MAX);
`endif

   logic [2:0]         state;
   logic               rdy_q;
   logic               pend_valid;
   logic signed [12:0] pend1, pend2;
   logic signed [12:0] tgt1, tgt2;
   logic [12:0]        rem1, rem2;
   logic [CW-1:0]      cnt;
   logic [SW-1:0]      scnt;

   logic               strobe;
   logic signed [12:0] cap1, cap2;
   logic [13:0]        delta1, delta2;
   logic [12:0]        abs1, abs2;
   logic               step_edge;
   logic [12:0]        rem1_nx, rem2_nx;

   // Edge detect, clamp, move distance and per-period step bookkeeping
   always_comb begin
      strobe    = dataReady & ~rdy_q;
      cap1      = limit(th1);
      cap2      = limit(th2);
      delta1    = {tgt1[12], tgt1} - {pos1[12], pos1};
      delta2    = {tgt2[12], tgt2} - {pos2[12], pos2};
      abs1      = delta1[13] ? 13'(14'd0 - delta1) : delta1[12:0];
      abs2      = delta2[13] ? 13'(14'd0 - delta2) : delta2[12:0];
      step_edge = (cnt == CNT_PW);
      rem1_nx   = (step_edge && rem1 != 13'd0) ? rem1 - 13'd1 : rem1;
      rem2_nx   = (step_edge && rem2 != 13'd0) ? rem2 - 13'd1 : rem2;
   end

   assign busy = (state != S_IDLE);

   // Move sequencer; step and moveDone are registered one cycle behind the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         rdy_q      <= 1'b0;
         pend_valid <= 1'b0;
         pend1      <= '0;
         pend2      <= '0;
         tgt1       <= '0;
         tgt2       <= '0;
         rem1       <= '0;
         rem2       <= '0;
         cnt        <= '0;
         scnt       <= '0;
         pos1       <= '0;
         pos2       <= '0;
         dir1       <= 1'b0;
         dir2       <= 1'b0;
         step1      <= 1'b0;
         step2      <= 1'b0;
         moveDone   <= 1'b0;
      end else begin
         rdy_q    <= dataReady;
         moveDone <= (state == S_DONE);
         step1    <= (state == S_RUN) && (cnt < CNT_PW) && (rem1 != 13'd0);
         step2    <= (state == S_RUN) && (cnt < CNT_PW) && (rem2 != 13'd0);

         // Any strobe outside IDLE (including the DONE->IDLE cycle) lands in pending
         if (state != S_IDLE && strobe) begin
            pend1      <= cap1;
            pend2      <= cap2;
            pend_valid <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (pend_valid) begin
                  tgt1  <= pend1;
                  tgt2  <= pend2;
                  state <= S_LOAD;
                  if (strobe) begin
                     pend1 <= cap1;
                     pend2 <= cap2;
                  end else begin
                     pend_valid <= 1'b0;
                  end
               end else if (strobe) begin
                  tgt1  <= cap1;
                  tgt2  <= cap2;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               rem1 <= abs1;
               rem2 <= abs2;
               if (abs1 == 13'd0 && abs2 == 13'd0) begin
                  state <= S_DONE;
               end else begin
                  dir1  <= ~delta1[13];
                  dir2  <= ~delta2[13];
                  scnt  <= '0;
                  state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (scnt == SU_LAST) begin
                  cnt   <= '0;
                  state <= S_RUN;
               end else begin
                  scnt <= scnt + SW'(1);
               end
            end
            S_RUN: begin
               cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
               rem1 <= rem1_nx;
               rem2 <= rem2_nx;
               if (step_edge && rem1 != 13'd0)
                  pos1 <= dir1 ? pos1 + 13'sd1 : pos1 - 13'sd1;
               if (step_edge && rem2 != 13'd0)
                  pos2 <= dir2 ? pos2 + 13'sd1 : pos2 - 13'sd1;
               if (cnt == CNT_LAST && rem1_nx == 13'd0 && rem2_nx == 13'd0)
                  state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
